// File: rtl/vr_cap_conditioner.sv
// VR/crank capture conditioner: synchronise, glitch-filter, and time rising edges
// to give hwag a clean level, a per-tooth strobe and the measured tooth period.
module vr_cap_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int PER_W       = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_in,
    input  logic [FILT_W-1:0] filt_len,
    input  logic [PER_W-1:0]  min_per,
    input  logic [PER_W-1:0]  max_per,
    output logic              cap_out,
    output logic              cap_stb,
    output logic [PER_W-1:0]  cap_per,
    output logic              cap_rej,
    output logic              cap_stall
);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        RUN
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [FILT_W-1:0]      filt_cnt;
    logic                   filt_done;
    logic                   rise;

    logic [PER_W-1:0]       per_cnt, per_cnt_d;
    logic [PER_W:0]         per_inc;
    logic [PER_W-1:0]       per_sat;
    logic                   at_max;
    logic                   too_short;

    logic                   stb_d;
    logic                   rej_d;
    logic [PER_W-1:0]       per_d;
    logic                   stall_d;

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], cap_in};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // A new level is adopted only after filt_len+1 consecutive differing samples.
    assign filt_done = (s != cap_out) && (filt_cnt == filt_len);
    assign rise      = filt_done && s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_out  <= 1'b0;
            filt_cnt <= '0;
        end else if (s == cap_out) begin
            filt_cnt <= '0;
        end else if (filt_done) begin
            cap_out  <= s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + FILT_W'(1);
        end
    end

    // Period arithmetic is one bit wider so per_cnt+1 can never wrap.
    assign per_inc   = {1'b0, per_cnt} + (PER_W + 1)'(1);
    assign at_max    = (per_cnt >= max_per);
    assign too_short = (per_inc < {1'b0, min_per});
    assign per_sat   = at_max ? max_per : per_inc[PER_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        per_cnt_d = per_sat;
        stb_d     = 1'b0;
        rej_d     = 1'b0;
        per_d     = cap_per;
        stall_d   = cap_stall;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = SYNC;
                    per_cnt_d = '0;
                end
            end
            SYNC, RUN: begin
                if (at_max) begin
                    // Timeout wins over a coincident edge: restart sync from it.
                    stall_d = 1'b1;
                    if (rise) begin
                        state_d   = SYNC;
                        per_cnt_d = '0;
                    end else begin
                        state_d   = IDLE;
                        per_cnt_d = max_per;
                    end
                end else if (rise) begin
                    if (too_short) begin
                        rej_d = 1'b1;
                    end else begin
                        stb_d     = 1'b1;
                        per_d     = per_inc[PER_W-1:0];
                        per_cnt_d = '0;
                        state_d   = RUN;
                        stall_d   = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt   <= '0;
            cap_stb   <= 1'b0;
            cap_rej   <= 1'b0;
            cap_per   <= '0;
            cap_stall <= 1'b1;
        end else begin
            per_cnt   <= per_cnt_d;
            cap_stb   <= stb_d;
            cap_rej   <= rej_d;
            cap_per   <= per_d;
            cap_stall <= stall_d;
        end
    end

endmodule

// File: tb/tb_vr_cap_conditioner.sv
// Directed bench for vr_cap_conditioner: a timestamp-based reference model is
// compared every cycle, plus hand-computed expectations for each scenario.
module tb_vr_cap_conditioner;

    localparam int SYNC_STAGES = 2;
    localparam int FILT_W      = 8;
    localparam int PER_W       = 24;

    logic              clk;
    logic              rst;
    logic              cap_in;
    logic [FILT_W-1:0] filt_len;
    logic [PER_W-1:0]  min_per;
    logic [PER_W-1:0]  max_per;
    logic              cap_out;
    logic              cap_stb;
    logic [PER_W-1:0]  cap_per;
    logic              cap_rej;
    logic              cap_stall;

    int n_checks = 0;
    int n_pass   = 0;

    vr_cap_conditioner #(
        .SYNC_STAGES(SYNC_STAGES),
        .FILT_W     (FILT_W),
        .PER_W      (PER_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cap_in   (cap_in),
        .filt_len (filt_len),
        .min_per  (min_per),
        .max_per  (max_per),
        .cap_out  (cap_out),
        .cap_stb  (cap_stb),
        .cap_per  (cap_per),
        .cap_rej  (cap_rej),
        .cap_stall(cap_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Reference model: tooth timing kept as edge timestamps rather than counters.
    bit              q_in[$];
    bit              win[$];
    bit              m_out, m_stb, m_rej, m_stall, m_armed;
    logic [PER_W-1:0] m_per;
    longint          m_n, m_ref;
    int              m_stb_cnt = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_in = {};
            repeat (SYNC_STAGES) q_in.push_back(1'b0);
            win     = {};
            m_out   = 1'b0;
            m_stb   = 1'b0;
            m_rej   = 1'b0;
            m_stall = 1'b1;
            m_per   = '0;
            m_armed = 1'b0;
            m_n     = 0;
            m_ref   = 0;
        end else begin
            bit     s;
            bit     rise;
            bit     all_diff;
            longint elapsed;
            m_n++;
            s = q_in[$];
            q_in.pop_back();
            q_in.push_front(cap_in);
            win.push_back(s);
            if (win.size() > int'(filt_len) + 1) win.pop_front();
            all_diff = (win.size() == int'(filt_len) + 1);
            foreach (win[i]) if (win[i] == m_out) all_diff = 1'b0;
            rise    = all_diff && !m_out;
            elapsed = m_n - m_ref;
            m_stb   = 1'b0;
            m_rej   = 1'b0;
            if (m_armed && (elapsed - 1 >= longint'(max_per))) begin
                m_stall = 1'b1;
                if (rise) m_ref = m_n;
                else m_armed = 1'b0;
            end else if (rise) begin
                if (!m_armed) begin
                    m_armed = 1'b1;
                    m_ref   = m_n;
                end else if (elapsed < longint'(min_per)) begin
                    m_rej = 1'b1;
                end else begin
                    m_stb   = 1'b1;
                    m_per   = PER_W'(elapsed);
                    m_ref   = m_n;
                    m_stall = 1'b0;
                    m_stb_cnt++;
                end
            end
            if (all_diff) m_out = !m_out;
        end
    end

    always @(negedge clk) begin
        check("outputs_vs_model",
              {cap_out, cap_stb, cap_rej, cap_stall, cap_per},
              {m_out, m_stb, m_rej, m_stall, m_per});
    end

    // Observed strobes/rejects for the per-scenario literal expectations.
    int               n_stb = 0;
    int               n_rej = 0;
    logic [PER_W-1:0] last_per;
    logic [PER_W-1:0] pers[$];

    always @(negedge clk) begin
        if (rst) begin
            if (cap_stb === 1'b1) begin
                n_stb++;
                last_per = cap_per;
                pers.push_back(cap_per);
            end
            if (cap_rej === 1'b1) n_rej++;
        end
    end

    task automatic clear_mon();
        n_stb = 0;
        n_rej = 0;
        pers  = {};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic tooth(input int hi, input int lo);
        cap_in = 1'b1;
        cycles(hi);
        cap_in = 1'b0;
        cycles(lo);
    endtask

    task automatic square_run();
        int bad;
        int base;
        cap_in = 1'b0;
        cycles(10);
        clear_mon();
        base   = m_stb_cnt;
        cap_in = 1'b1;
        cycles(5);
        check("latency_before", cap_out, 0);
        cycles(1);
        check("latency_at_6", cap_out, 1);
        check("first_rise_no_stb", cap_stb, 0);
        check("stall_before_first_stb", cap_stall, 1);
        cycles(58);
        cap_in = 1'b0;
        cycles(64);
        cap_in = 1'b1;
        cycles(6);
        check("second_rise_stb", cap_stb, 1);
        check("second_rise_per", cap_per, 128);
        check("stall_drops_at_stb", cap_stall, 0);
        cycles(58);
        cap_in = 1'b0;
        cycles(64);
        repeat (4) tooth(64, 64);
        check("square_stb_count", n_stb, 5);
        check("square_rej_count", n_rej, 0);
        bad = 0;
        foreach (pers[i]) if (pers[i] != 128) bad++;
        check("square_periods_128", bad, 0);
        check("model_square_stb_count", m_stb_cnt - base, 5);
    endtask

    initial begin
        cap_in   = 1'b0;
        rst      = 1'b1;
        filt_len = 3;
        min_per  = 16;
        max_per  = 1000;
        #1 rst = 1'b0;
        #2;
        check("reset_state", {cap_out, cap_stb, cap_rej, cap_stall, cap_per},
              {1'b0, 1'b0, 1'b0, 1'b1, 24'd0});
        cycles(3);
        rst = 1'b1;

        // Clean square wave, 128-cycle pitch.
        square_run();

        // Glitches of 1..3 cycles are swallowed; a 4-cycle pulse passes.
        for (int k = 1; k <= 3; k++) begin
            cap_in = 1'b1;
            cycles(k);
            cap_in = 1'b0;
            cycles(10);
            check("glitch_suppressed", cap_out, 0);
        end
        cap_in = 1'b1;
        cycles(4);
        cap_in = 1'b0;
        cycles(2);
        check("pulse4_passes", cap_out, 1);
        cycles(10);
        check("pulse4_falls", cap_out, 0);

        // Short extra pulse 40 cycles after a tooth is rejected with min_per=100.
        min_per = 100;
        tooth(64, 64);
        tooth(64, 64);
        clear_mon();
        tooth(20, 20);
        tooth(20, 68);
        tooth(64, 64);
        check("short_rej_count", n_rej, 1);
        check("short_stb_count", n_stb, 2);
        check("after_rej_per", last_per, 128);

        // 60-2 style gap: two missing teeth give a 384-cycle period.
        min_per = 16;
        clear_mon();
        repeat (3) tooth(64, 64);
        tooth(64, 320);
        repeat (2) tooth(64, 64);
        check("gap_stb_count", pers.size(), 6);
        if (pers.size() == 6) begin
            check("gap_per_before", pers[3], 128);
            check("gap_per_missing", pers[4], 384);
            check("gap_per_after", pers[5], 128);
        end
        check("gap_no_stall", cap_stall, 0);

        // Stall after max_per=500 idle cycles, then resynchronise.
        max_per = 500;
        tooth(64, 64);
        cap_in = 1'b1;
        cycles(64);
        cap_in = 1'b0;
        cycles(442);
        check("stall_not_yet", cap_stall, 0);
        cycles(1);
        check("stall_at_max", cap_stall, 1);
        check("model_stall_at_max", m_stall, 1);
        cycles(100);
        clear_mon();
        tooth(64, 64);
        check("resync_no_stb", n_stb, 0);
        check("resync_still_stalled", cap_stall, 1);
        tooth(64, 64);
        check("resync_stb", n_stb, 1);
        check("resync_per", last_per, 128);
        check("resync_stall_clear", cap_stall, 0);

        // Asynchronous reset mid-tooth, between clock edges.
        max_per = 1000;
        cap_in  = 1'b1;
        cycles(20);
        #1 rst = 1'b0;
        #1;
        check("async_reset_state", {cap_out, cap_stb, cap_rej, cap_stall, cap_per},
              {1'b0, 1'b0, 1'b0, 1'b1, 24'd0});
        cap_in = 1'b0;
        cycles(5);
        rst = 1'b1;
        square_run();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
